program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
// - Boot-time loader sitting directly upstream of the instruction and data BRAMs (bram32) and the pc stall input.
// - Consumes a framed byte stream (valid/ready, e.g. from a UART receiver) and writes 32-bit words into either BRAM.
// - Releases the core: drops pc_stall and hands data-BRAM write ownership to the datapath (d_bram_init_done).
// PARAMETERS
// - ADDR_WIDTH  10     BRAM byte-address width (word i written at address i*4)
// - DATA_WIDTH  32     BRAM word width
// - MAX_WORDS   256    max words per frame (= `I_BRAM_DEPTH); larger count is an error
// - MAGIC       8'hA5  frame start byte
// PORTS
// - clk               in   1           system clock
// - rst               in   1           synchronous reset, ACTIVE-LOW (0 = reset)
// - s_data            in   8           stream byte
// - s_valid           in   1           s_data valid
// - s_ready           out  1           loader accepts byte; transfer when s_valid & s_ready at posedge clk
// - i_w_addr          out  ADDR_WIDTH  instruction BRAM write address
// - i_w_dat           out  DATA_WIDTH  instruction BRAM write data
// - i_w_enb           out  1           instruction BRAM write enable (1-cycle pulse per word)
// - d_w_addr          out  ADDR_WIDTH  data BRAM write address
// - d_w_dat           out  DATA_WIDTH  data BRAM write data
// - d_w_enb           out  1           data BRAM write enable (1-cycle pulse per word)
// - d_bram_init_done  out  1           1 = datapath owns data BRAM write port
// - pc_stall          out  1           1 = pc held
// - instr_loaded      out  1           an instruction frame passed checksum
// - err               out  1           last frame failed; cleared when next MAGIC accepted
// BEHAVIOUR
// - Clock and reset: one clock; reset synchronous and active-low. rst==0 at a posedge: state<=IDLE, all addr/dat 0, enables 0,
//   d_bram_init_done 0, pc_stall 1, instr_loaded 0, err 0, partial word/count/checksum discarded; s_ready 0 while rst==0.
// - Frame: MAGIC, TGT, CNT_LO, CNT_HI, CNT words (4 bytes each, little-endian), CSUM (XOR of all word bytes).
//   TGT 8'h00 = instr BRAM, 8'h01 = data BRAM, 8'hFF = RUN (frame is MAGIC, FF only).
// - States: IDLE, TGT, CNT_LO, CNT_HI, DATA, WRITE, CSUM, RUN.
//   IDLE: non-MAGIC bytes accepted and dropped; MAGIC -> TGT, err<=0.
//   TGT: 00/01 -> CNT_LO; FF -> RUN if instr_loaded else err<=1, IDLE; other -> err<=1, IDLE.
//   CNT_LO -> CNT_HI; CNT_HI: count==0 -> CSUM; count>MAX_WORDS -> err<=1, IDLE (no writes); else -> DATA.
//   DATA: shift byte into word (byte0 = bits 7:0); 4th byte -> WRITE.
//   WRITE: exactly one cycle; s_ready=0; selected *_w_enb=1, *_w_addr=idx<<2, *_w_dat=word; idx++;
//   -> CSUM if idx==count else DATA. Enable rises the cycle after the 4th byte handshake.
//   CSUM: byte==XOR -> if TGT==00, instr_loaded<=1; mismatch -> err<=1 (words already written stay; flag not set). -> IDLE.
//   RUN: entered the cycle after FF accepted; pc_stall<=0, d_bram_init_done<=1 on that edge; s_ready=0; terminal until reset.
// - s_ready = 1 in every state except WRITE and RUN (and during reset). s_valid gaps allowed anywhere; no timeout.
// - Addresses: idx is a 16-bit counter; address = idx[ADDR_WIDTH-3:0]<<2; MAX_WORDS bound prevents wrap.
// - New instr frame clears instr_loaded at its TGT byte; data frames don't affect instr_loaded.
// - Enables are 0 in every state except WRITE; addr/dat hold last written values otherwise.
// STRUCTURE
// - rv32i_params.vh: `LDR_MAGIC, `LDR_TGT_INSTR, `LDR_TGT_DATA, `LDR_TGT_RUN; state encodings in rv32i_control.vh.
// - One sub-module: ldr_word_assembler (byte shift register + 2-bit byte counter, word_valid on 4th byte, clear input).
// - FSM, word/count/index counters, checksum register and output registers in program_loader.
// TESTING
// 1) A5 00 02 00 93 00 10 00 13 01 20 00 B1 -> i_w_enb pulses at 0x000 data 00100093 and 0x004 data 00200113;
//    instr_loaded=1, err=0.
// 2) Same frame with CSUM 00 -> err=1, instr_loaded=0; then A5 FF -> err=1, pc_stall stays 1.
// 3) A5 01 01 01 (count 257) -> err=1 after CNT_HI, no d_w_enb.
// 4) Test 1 frame, data frame of 3 words (1,2,3), then A5 FF -> d_w_enb at 0x000/0x004/0x008;
//    pc_stall 1->0 and d_bram_init_done 0->1 one cycle after FF; s_ready=0 after.
// 5) s_valid held high with back-to-back bytes -> byte after each 4th byte waits one cycle (WRITE), none lost/duplicated;
//    random s_valid gaps give identical writes.
// 6) rst=0 after 2 word bytes -> all outputs at reset values next edge; full test-1 frame then loads correctly from 0x000.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared constants and FSM state type for the boot-time program loader.
package program_loader_pkg;

  localparam logic [7:0] LDR_MAGIC     = 8'hA5;
  localparam logic [7:0] LDR_TGT_INSTR = 8'h00;
  localparam logic [7:0] LDR_TGT_DATA  = 8'h01;
  localparam logic [7:0] LDR_TGT_RUN   = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StTgt,
    StCntLo,
    StCntHi,
    StData,
    StWrite,
    StCsum,
    StRun
  } ldr_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in, instruction/data BRAM write ports and core-release status out.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [7:0]            s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] i_w_addr;
  logic [DATA_WIDTH-1:0] i_w_dat;
  logic                  i_w_enb;
  logic [ADDR_WIDTH-1:0] d_w_addr;
  logic [DATA_WIDTH-1:0] d_w_dat;
  logic                  d_w_enb;
  logic                  d_bram_init_done;
  logic                  pc_stall;
  logic                  instr_loaded;
  logic                  err;

  modport master (
    input  s_data, s_valid,
    output s_ready, i_w_addr, i_w_dat, i_w_enb, d_w_addr, d_w_dat, d_w_enb,
           d_bram_init_done, pc_stall, instr_loaded, err
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready, i_w_addr, i_w_dat, i_w_enb, d_w_addr, d_w_dat, d_w_enb,
           d_bram_init_done, pc_stall, instr_loaded, err
  );
endinterface

// File: rtl/ldr_word_assembler.sv
// Packs four little-endian stream bytes into a 32-bit word; word_valid marks the 4th byte.
module ldr_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0]  cnt_q;
  logic [23:0] sh_q;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (push) begin
      cnt_q <= cnt_q + 2'd1;
      sh_q  <= {data, sh_q[23:8]};
    end
  end

  // The 4th byte is taken straight from the input so the word is ready on its handshake.
  assign word       = {data, sh_q};
  assign word_valid = push && (cnt_q == 2'd3);
endmodule

// File: rtl/program_loader.sv
// Framed byte-stream boot loader: writes words into instruction/data BRAM, then releases the core.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WORDS  = 256,
  parameter logic [7:0]  MAGIC      = LDR_MAGIC
) (
  input  logic             clk,
  input  logic             rst,
  program_loader_if.master bus
);
  localparam logic [15:0] MaxWords = 16'(MAX_WORDS);

  ldr_state_e            state_q, state_d;
  logic                  tgt_data_q, tgt_data_d;
  logic [15:0]           count_q, count_d, idx_q, idx_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH-1:0] i_w_addr_q, i_w_addr_d, d_w_addr_q, d_w_addr_d;
  logic [DATA_WIDTH-1:0] i_w_dat_q, i_w_dat_d, d_w_dat_q, d_w_dat_d;
  logic                  i_w_enb_q, i_w_enb_d, d_w_enb_q, d_w_enb_d;
  logic                  err_q, err_d, instr_loaded_q, instr_loaded_d;
  logic                  pc_stall_q, pc_stall_d, init_done_q, init_done_d;

  logic                  s_ready, hs, asm_push, asm_clear, word_valid;
  logic [31:0]           word;
  logic [15:0]           cnt_full, idx_inc;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign s_ready   = rst && (state_q != StWrite) && (state_q != StRun);
  assign hs        = bus.s_valid && s_ready;
  assign asm_push  = hs && (state_q == StData);
  assign asm_clear = hs && (state_q == StIdle) && (bus.s_data == MAGIC);
  assign cnt_full  = {bus.s_data, count_q[7:0]};
  assign idx_inc   = idx_q + 16'd1;
  assign word_addr = {idx_q[ADDR_WIDTH-3:0], 2'b00};

  ldr_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .push       (asm_push),
    .data       (bus.s_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d        = state_q;
    tgt_data_d     = tgt_data_q;
    count_d        = count_q;
    idx_d          = idx_q;
    csum_d         = csum_q;
    i_w_addr_d     = i_w_addr_q;
    i_w_dat_d      = i_w_dat_q;
    d_w_addr_d     = d_w_addr_q;
    d_w_dat_d      = d_w_dat_q;
    i_w_enb_d      = 1'b0;
    d_w_enb_d      = 1'b0;
    err_d          = err_q;
    instr_loaded_d = instr_loaded_q;
    pc_stall_d     = pc_stall_q;
    init_done_d    = init_done_q;

    unique case (state_q)
      StIdle: begin
        if (hs && bus.s_data == MAGIC) begin
          state_d = StTgt;
          err_d   = 1'b0;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      StTgt: begin
        if (hs) begin
          case (bus.s_data)
            LDR_TGT_INSTR: begin
              tgt_data_d     = 1'b0;
              instr_loaded_d = 1'b0;
              state_d        = StCntLo;
            end
            LDR_TGT_DATA: begin
              tgt_data_d = 1'b1;
              state_d    = StCntLo;
            end
            LDR_TGT_RUN: begin
              if (instr_loaded_q) begin
                state_d     = StRun;
                pc_stall_d  = 1'b0;
                init_done_d = 1'b1;
              end else begin
                err_d   = 1'b1;
                state_d = StIdle;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = StIdle;
            end
          endcase
        end
      end
      StCntLo: begin
        if (hs) begin
          count_d = {8'h00, bus.s_data};
          state_d = StCntHi;
        end
      end
      StCntHi: begin
        if (hs) begin
          count_d = cnt_full;
          if (cnt_full == '0) begin
            state_d = StCsum;
          end else if (cnt_full > MaxWords) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (hs) begin
          csum_d = csum_q ^ bus.s_data;
          if (word_valid) begin
            state_d = StWrite;
            if (tgt_data_q) begin
              d_w_enb_d  = 1'b1;
              d_w_addr_d = word_addr;
              d_w_dat_d  = DATA_WIDTH'(word);
            end else begin
              i_w_enb_d  = 1'b1;
              i_w_addr_d = word_addr;
              i_w_dat_d  = DATA_WIDTH'(word);
            end
          end
        end
      end
      StWrite: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == count_q) ? StCsum : StData;
      end
      StCsum: begin
        if (hs) begin
          // Words already written stay in BRAM on a mismatch; only the flags differ.
          if (bus.s_data == csum_q) begin
            if (!tgt_data_q) instr_loaded_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      StRun: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      tgt_data_q     <= 1'b0;
      count_q        <= '0;
      idx_q          <= '0;
      csum_q         <= '0;
      i_w_addr_q     <= '0;
      i_w_dat_q      <= '0;
      d_w_addr_q     <= '0;
      d_w_dat_q      <= '0;
      i_w_enb_q      <= 1'b0;
      d_w_enb_q      <= 1'b0;
      err_q          <= 1'b0;
      instr_loaded_q <= 1'b0;
      pc_stall_q     <= 1'b1;
      init_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      tgt_data_q     <= tgt_data_d;
      count_q        <= count_d;
      idx_q          <= idx_d;
      csum_q         <= csum_d;
      i_w_addr_q     <= i_w_addr_d;
      i_w_dat_q      <= i_w_dat_d;
      d_w_addr_q     <= d_w_addr_d;
      d_w_dat_q      <= d_w_dat_d;
      i_w_enb_q      <= i_w_enb_d;
      d_w_enb_q      <= d_w_enb_d;
      err_q          <= err_d;
      instr_loaded_q <= instr_loaded_d;
      pc_stall_q     <= pc_stall_d;
      init_done_q    <= init_done_d;
    end
  end

  assign bus.s_ready          = s_ready;
  assign bus.i_w_addr         = i_w_addr_q;
  assign bus.i_w_dat          = i_w_dat_q;
  assign bus.i_w_enb          = i_w_enb_q;
  assign bus.d_w_addr         = d_w_addr_q;
  assign bus.d_w_dat          = d_w_dat_q;
  assign bus.d_w_enb          = d_w_enb_q;
  assign bus.d_bram_init_done = init_done_q;
  assign bus.pc_stall         = pc_stall_q;
  assign bus.instr_loaded     = instr_loaded_q;
  assign bus.err              = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected BRAM writes are queued as bytes are sent.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int unsigned AW = 10;

  typedef struct packed {
    logic          tgt;
    logic [AW-1:0] addr;
    logic [31:0]   dat;
    logic [31:0]   cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  program_loader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (32),
    .MAX_WORDS  (256),
    .MAGIC      (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          last_hs = 0;
  int          frame_start = 0;
  wr_t         obs[$];
  wr_t         expq[$];
  logic [31:0] wq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write pulse with the cycle it appeared in.
  always @(negedge clk) begin
    if (bus.i_w_enb) obs.push_back('{tgt: 1'b0, addr: bus.i_w_addr, dat: bus.i_w_dat, cyc: 32'(cyc)});
    if (bus.d_w_enb) obs.push_back('{tgt: 1'b1, addr: bus.d_w_addr, dat: bus.d_w_dat, cyc: 32'(cyc)});
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick_gap(input int m);
    return (m == 0) ? 0 : int'($urandom_range(m, 0));
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit done = 1'b0;
    bus.s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      if (bus.s_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    last_hs = cyc;
    check("handshake", 96'(done), 96'(1));
  endtask

  task automatic send_frame(input logic [7:0] tgt, input int csum_val, input int maxgap);
    logic [7:0]  cs = 8'h00;
    logic [15:0] n  = 16'(wq.size());
    logic [31:0] w;
    send_byte(LDR_MAGIC, pick_gap(maxgap));
    frame_start = last_hs;
    send_byte(tgt, pick_gap(maxgap));
    send_byte(n[7:0], pick_gap(maxgap));
    send_byte(n[15:8], pick_gap(maxgap));
    foreach (wq[i]) begin
      w = wq[i];
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8], pick_gap(maxgap));
        cs = cs ^ w[8*j +: 8];
      end
      expq.push_back('{tgt: (tgt == LDR_TGT_DATA), addr: AW'(i * 4), dat: w, cyc: 32'(last_hs)});
    end
    send_byte((csum_val < 0) ? cs : 8'(csum_val), pick_gap(maxgap));
  endtask

  task automatic check_writes(input string tag);
    wr_t o;
    wr_t e;
    repeat (3) @(negedge clk);
    check({tag, "_count"}, 96'(obs.size()), 96'(expq.size()));
    while (obs.size() > 0 && expq.size() > 0) begin
      o = obs.pop_front();
      e = expq.pop_front();
      check(tag, 96'(o), 96'(e));
    end
    obs.delete();
    expq.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, 96'({bus.s_ready, bus.pc_stall, bus.d_bram_init_done, bus.instr_loaded,
                              bus.err, bus.i_w_enb, bus.d_w_enb}), 96'(7'b0100000));
    check({tag, "_addr"}, 96'({bus.i_w_addr, bus.d_w_addr}), 96'(0));
    check({tag, "_dat"}, 96'({bus.i_w_dat, bus.d_w_dat}), 96'(0));
  endtask

  initial begin
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    rst         = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    @(negedge clk);

    // Two-word instruction frame with a good checksum.
    wq = '{32'h00100093, 32'h00200113};
    send_frame(LDR_TGT_INSTR, -1, 0);
    check_writes("t1_wr");
    check("t1_loaded", 96'(bus.instr_loaded), 96'(1));
    check("t1_err", 96'(bus.err), 96'(0));

    // Same frame, bad checksum: words still land, flag cleared, RUN refused.
    send_frame(LDR_TGT_INSTR, 0, 0);
    check_writes("t2_wr");
    check("t2_err", 96'(bus.err), 96'(1));
    check("t2_loaded", 96'(bus.instr_loaded), 96'(0));
    send_byte(LDR_MAGIC, 0);
    check("t2_err_clr", 96'(bus.err), 96'(0));
    send_byte(LDR_TGT_RUN, 0);
    @(negedge clk);
    check("t2_run_err", 96'(bus.err), 96'(1));
    check("t2_stall", 96'(bus.pc_stall), 96'(1));
    check("t2_ready", 96'(bus.s_ready), 96'(1));

    // Count 257 exceeds the limit.
    send_byte(LDR_MAGIC, 0);
    send_byte(LDR_TGT_DATA, 0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("t3_err", 96'(bus.err), 96'(1));
    check_writes("t3_wr");

    // Back-to-back bytes: 4 words -> 21 post-magic cycles of bytes/writes plus 3 header bytes.
    wq = '{32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D, 32'h000000A5};
    send_frame(LDR_TGT_INSTR, -1, 0);
    check("t5_span", 96'(last_hs - frame_start), 96'(24));
    check_writes("t5_wr");
    check("t5_loaded", 96'(bus.instr_loaded), 96'(1));
    send_frame(LDR_TGT_INSTR, -1, 3);
    check_writes("t5_gap_wr");
    check("t5_gap_loaded", 96'(bus.instr_loaded), 96'(1));
    check("t5_gap_err", 96'(bus.err), 96'(0));

    // Reset in the middle of a word, then a clean reload from address 0.
    send_byte(LDR_MAGIC, 0);
    send_byte(LDR_TGT_INSTR, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b0;
    @(negedge clk);
    check_reset("t6_rst");
    rst = 1'b1;
    @(negedge clk);
    wq = '{32'h00100093, 32'h00200113};
    send_frame(LDR_TGT_INSTR, -1, 0);
    check_writes("t6_wr");
    check("t6_loaded", 96'(bus.instr_loaded), 96'(1));

    // Data frame, then RUN releases the core.
    wq = '{32'h00000001, 32'h00000002, 32'h00000003};
    send_frame(LDR_TGT_DATA, -1, 0);
    check_writes("t4_wr");
    check("t4_loaded_kept", 96'(bus.instr_loaded), 96'(1));
    send_byte(LDR_MAGIC, 0);
    check("t4_pre_run", 96'({bus.pc_stall, bus.d_bram_init_done}), 96'(2'b10));
    send_byte(LDR_TGT_RUN, 0);
    check("t4_run", 96'({bus.pc_stall, bus.d_bram_init_done, bus.s_ready}), 96'(3'b010));
    repeat (4) @(negedge clk);
    check("t4_run_hold", 96'({bus.pc_stall, bus.d_bram_init_done, bus.s_ready}), 96'(3'b010));
    check_writes("t4_run_wr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
